// File: rtl/rram_arb_pkg.sv
// Shared encodings for the NEUROMORPHIC_X1 port arbiter: FSM states, R_WB and
// requester-id constants, and the default watchdog limit.
package rram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam logic RWB_READ  = 1'b1;
  localparam logic RWB_WRITE = 1'b0;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/rram_arb_rr_pick.sv
// Two-way round-robin picker. The pointer only moves when both requesters
// compete, so a lone requester never steals the other's next turn.
module rram_arb_rr_pick
  import rram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic grant_id,
  output logic grant_valid
);

  logic ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= REQ0;
    end else if (advance && valid0 && valid1) begin
      ptr <= ~grant_id;
    end
  end

  always_comb begin
    grant_valid = valid0 | valid1;
    grant_id    = REQ0;
    if (valid0 && valid1) begin
      grant_id = ptr;
    end else if (valid1) begin
      grant_id = REQ1;
    end
  end

endmodule

// File: rtl/rram_port_arbiter.sv
// Shares the NEUROMORPHIC_X1 functional port between a host and an engine, with
// a watchdog abort. Optional counters are enabled by RRAM_ARB_STATS_EN.
module rram_port_arbiter
  import rram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int TO_W           = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req0_valid,
  input  logic        req0_rwb,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_sel,
  output logic        req0_ready,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_rwb,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_sel,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic        req1_err,
  output logic        EN,
  output logic        R_WB,
  output logic [31:0] DI,
  output logic [31:0] AD,
  output logic [3:0]  SEL,
  input  logic [31:0] DO,
  input  logic        func_ack,
  output logic        busy,
  output logic        timeout_sticky
`ifdef RRAM_ARB_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [7:0]  stat_timeouts
`endif
);

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  arb_state_e      state, state_next;
  logic            grant_id, grant_valid, pick_advance;
  logic            cur_id;
  logic [TO_W-1:0] wd;
  logic            wd_expired;
  logic [31:0]     ack_rdata;

  rram_arb_rr_pick u_pick (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .advance    (pick_advance),
    .grant_id   (grant_id),
    .grant_valid(grant_valid)
  );

  assign wd_expired = (wd == WD_LAST);
  assign busy       = (state != ST_IDLE);
  assign ack_rdata  = (R_WB == RWB_READ) ? DO : 32'h0;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_next;
  end

  // func_ack is tested before expiry so a same-cycle ack completes cleanly
  always_comb begin
    state_next   = state;
    pick_advance = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          pick_advance = 1'b1;
          state_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (func_ack || wd_expired) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Every port is registered; EN is high exactly for the WAIT cycles
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      req0_ready     <= 1'b0;
      req1_ready     <= 1'b0;
      req0_done      <= 1'b0;
      req1_done      <= 1'b0;
      req0_err       <= 1'b0;
      req1_err       <= 1'b0;
      req0_rdata     <= 32'h0;
      req1_rdata     <= 32'h0;
      EN             <= 1'b0;
      R_WB           <= 1'b0;
      DI             <= 32'h0;
      AD             <= 32'h0;
      SEL            <= 4'h0;
      cur_id         <= REQ0;
      wd             <= '0;
      timeout_sticky <= 1'b0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_err   <= 1'b0;
      req1_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            cur_id <= grant_id;
            if (grant_id == REQ1) begin
              req1_ready <= 1'b1;
              R_WB       <= req1_rwb;
              AD         <= req1_addr;
              DI         <= req1_wdata;
              SEL        <= req1_sel;
            end else begin
              req0_ready <= 1'b1;
              R_WB       <= req0_rwb;
              AD         <= req0_addr;
              DI         <= req0_wdata;
              SEL        <= req0_sel;
            end
          end
        end
        ST_ISSUE: begin
          wd <= '0;
          EN <= 1'b1;
        end
        ST_WAIT: begin
          wd <= wd + 1'b1;
          if (func_ack || wd_expired) begin
            EN <= 1'b0;
            if (!func_ack) timeout_sticky <= 1'b1;
            if (cur_id == REQ1) begin
              req1_done  <= 1'b1;
              req1_err   <= ~func_ack;
              req1_rdata <= func_ack ? ack_rdata : 32'h0;
            end else begin
              req0_done  <= 1'b1;
              req0_err   <= ~func_ack;
              req0_rdata <= func_ack ? ack_rdata : 32'h0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RRAM_ARB_STATS_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stat_ops      <= 16'h0;
      stat_timeouts <= 8'h0;
    end else if (state == ST_DONE) begin
      stat_ops <= stat_ops + 16'h1;
      if ((req0_err || req1_err) && (stat_timeouts != 8'hFF)) begin
        stat_timeouts <= stat_timeouts + 8'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rram_port_arbiter.sv
// Directed bench for rram_port_arbiter with a transaction-level reference model
// compared every cycle; build with RRAM_ARB_STATS_EN to also check the counters.
module tb_rram_port_arbiter;

  localparam int TOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req0_rwb = 0, req1_valid = 0, req1_rwb = 0;
  logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic [3:0]  req0_sel = 0, req1_sel = 0;
  logic        req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic        EN, R_WB, busy, timeout_sticky;
  logic [31:0] DI, AD;
  logic [3:0]  SEL;
  logic [31:0] DO = 0;
  logic        func_ack = 0;
`ifdef RRAM_ARB_STATS_EN
  logic [15:0] stat_ops;
  logic [7:0]  stat_timeouts;
`endif

  rram_port_arbiter #(.TIMEOUT_CYCLES(TOUT), .TO_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req0_valid(req0_valid), .req0_rwb(req0_rwb), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_sel(req0_sel), .req0_ready(req0_ready),
    .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_rwb(req1_rwb), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_sel(req1_sel), .req1_ready(req1_ready),
    .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
`ifdef RRAM_ARB_STATS_EN
    .stat_ops(stat_ops), .stat_timeouts(stat_timeouts),
`endif
    .EN(EN), .R_WB(R_WB), .DI(DI), .AD(AD), .SEL(SEL), .DO(DO),
    .func_ack(func_ack), .busy(busy), .timeout_sticky(timeout_sticky)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_failed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference model: one accepted command at a time, tracked as a phase
  // (0 free, 1 accepted, 2 on the macro, 3 reported) plus an EN-cycle count.
  int          m_phase = 0, m_en_cnt = 0;
  bit          m_ptr = 0, m_id = 0, m_rwb = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [3:0]  m_sel = 0;
  bit          e_ready0 = 0, e_ready1 = 0, e_done0 = 0, e_done1 = 0;
  bit          e_err0 = 0, e_err1 = 0, e_en = 0, e_sticky = 0;
  logic [31:0] e_rdata0 = 0, e_rdata1 = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_phase = 0; m_en_cnt = 0; m_ptr = 0; m_id = 0;
      e_ready0 = 0; e_ready1 = 0; e_done0 = 0; e_done1 = 0;
      e_err0 = 0; e_err1 = 0; e_en = 0; e_sticky = 0;
      e_rdata0 = 0; e_rdata1 = 0;
    end else begin
      e_ready0 = 0; e_ready1 = 0; e_done0 = 0; e_done1 = 0; e_err0 = 0; e_err1 = 0;
      if (m_phase == 0) begin
        if (req0_valid || req1_valid) begin
          if (req0_valid && req1_valid) begin
            m_id = m_ptr;
            m_ptr = !m_ptr;
          end else begin
            m_id = req1_valid;
          end
          m_rwb   = m_id ? req1_rwb   : req0_rwb;
          m_addr  = m_id ? req1_addr  : req0_addr;
          m_wdata = m_id ? req1_wdata : req0_wdata;
          m_sel   = m_id ? req1_sel   : req0_sel;
          if (m_id) e_ready1 = 1; else e_ready0 = 1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        e_en = 1; m_en_cnt = 1; m_phase = 2;
      end else if (m_phase == 2) begin
        if (func_ack || m_en_cnt == TOUT) begin
          logic [31:0] v;
          v = (func_ack && m_rwb) ? DO : 32'h0;
          if (!func_ack) e_sticky = 1;
          if (m_id) begin e_done1 = 1; e_err1 = !func_ack; e_rdata1 = v; end
          else      begin e_done0 = 1; e_err0 = !func_ack; e_rdata0 = v; end
          e_en = 0; m_phase = 3;
        end else begin
          m_en_cnt++;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // Macro responder: func_ack on EN-cycle index ack_delay (0 = first EN cycle).
  int          ack_delay = -1;
  logic [31:0] ack_data = 0;
  int          en_idx = 0;
  bit          prev_en = 0;
  initial forever begin
    @(posedge clk); #2;
    if (EN) en_idx = prev_en ? en_idx + 1 : 0;
    prev_en  = EN;
    func_ack = EN && (ack_delay >= 0) && (en_idx == ack_delay);
    DO       = ack_data;
  end

  // Per-cycle compare plus a few timeline observations for literal checks.
  int cyc = 0, en_run = 0, last_en_len = 0, gap = 0, min_gap = 1000;
  int ack_cyc = 0, done_cyc = 0, done_count = 0;
  bit had_pulse = 0, req1_activity = 0;
  int grants[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    chk("ready0", req0_ready, e_ready0);
    chk("ready1", req1_ready, e_ready1);
    chk("done0", req0_done, e_done0);
    chk("done1", req1_done, e_done1);
    chk("err0", req0_err, e_err0);
    chk("err1", req1_err, e_err1);
    chk("rdata0", req0_rdata, e_rdata0);
    chk("rdata1", req1_rdata, e_rdata1);
    chk("en", EN, e_en);
    chk("busy", busy, m_phase != 0);
    chk("sticky", timeout_sticky, e_sticky);
    if (e_en) begin
      chk("r_wb", R_WB, m_rwb);
      chk("ad", AD, m_addr);
      chk("di", DI, m_wdata);
      chk("sel", SEL, m_sel);
    end
    if (EN) begin
      if (en_run == 0 && had_pulse && gap < min_gap) min_gap = gap;
      en_run++; gap = 0; had_pulse = 1;
    end else begin
      if (en_run > 0) last_en_len = en_run;
      en_run = 0; gap++;
    end
    if (EN && func_ack) ack_cyc = cyc;
    if (req0_done || req1_done) begin done_cyc = cyc; done_count++; end
    if (req0_ready) grants.push_back(0);
    if (req1_ready) grants.push_back(1);
    if (req1_ready || req1_done || req1_err || req1_rdata != 0) req1_activity = 1;
  end

  bit          last_err;
  logic [31:0] last_rdata;

  task automatic run_op(input bit id, input bit rwb, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int dly, input logic [31:0] dov);
    bit seen;
    ack_delay = dly; ack_data = dov;
    if (id) begin req1_rwb = rwb; req1_addr = a; req1_wdata = d; req1_sel = s; req1_valid = 1; end
    else    begin req0_rwb = rwb; req0_addr = a; req0_wdata = d; req0_sel = s; req0_valid = 1; end
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = id ? req1_ready : req0_ready;
    end
    if (!seen) begin n_tests++; n_failed++; $display("FAIL ready_timeout: got no ready, expected one"); end
    @(posedge clk); #2;
    req0_valid = 0; req1_valid = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = id ? req1_done : req0_done;
    end
    if (!seen) begin n_tests++; n_failed++; $display("FAIL done_timeout: got no done, expected one"); end
    last_err   = id ? req1_err : req0_err;
    last_rdata = id ? req1_rdata : req0_rdata;
    #1;
  endtask

  initial begin
    int dcount;
    bit seen;
    repeat (3) @(posedge clk);
    #2 rst = 0;

    // single write, ack on the 4th EN cycle
    req1_activity = 0;
    run_op(0, 0, 32'h10, 32'hA5A5_0001, 4'hF, 3, 32'hFFFF_FFFF);
    chk("t1_en_len", last_en_len, 4);
    chk("t1_done_lat", done_cyc - ack_cyc, 1);
    chk("t1_err", last_err, 0);
    chk("t1_wr_rdata", last_rdata, 32'h0);
    chk("t1_req1_quiet", req1_activity, 0);

    // read on req1
    run_op(1, 1, 32'h20, 32'h0, 4'hF, 1, 32'hDEAD_BEEF);
    chk("t2_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("t2_err", last_err, 0);

    // ack on the expiry cycle: no error, sticky untouched
    run_op(0, 0, 32'h30, 32'h5555_AAAA, 4'h3, TOUT - 1, 32'h0BAD_F00D);
    chk("t5_en_len", last_en_len, TOUT);
    chk("t5_err", last_err, 0);
    chk("t5_sticky", timeout_sticky, 0);

    run_op(0, 1, 32'h40, 32'h0, 4'hF, 0, 32'h1234_5678);
    chk("rd0_rdata", last_rdata, 32'h1234_5678);

    // no ack: watchdog abort
    run_op(0, 1, 32'h44, 32'h0, 4'hF, -1, 32'hCAFE_F00D);
    chk("t4_en_len", last_en_len, TOUT);
    chk("t4_err", last_err, 1);
    chk("t4_rdata", last_rdata, 32'h0);
    chk("t4_sticky", timeout_sticky, 1);
`ifdef RRAM_ARB_STATS_EN
    chk("t4_stat_ops", stat_ops, 16'd5);
    chk("t4_stat_to", stat_timeouts, 8'd1);
`endif
    run_op(1, 0, 32'h48, 32'h1111_2222, 4'hC, 2, 32'h0);
    chk("t4b_err", last_err, 0);
    chk("t4b_sticky", timeout_sticky, 1);

    // async reset while a command hangs on the macro
    ack_delay = -1;
    @(posedge clk); #2;
    req0_rwb = 1; req0_addr = 32'h50; req0_sel = 4'hF;
    req1_rwb = 0; req1_addr = 32'h60; req1_wdata = 32'h6666_0000; req1_sel = 4'h1;
    req0_valid = 1; req1_valid = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = req0_ready || req1_ready;
    end
    chk("t6_pre_grant0", req0_ready, 1);
    @(posedge clk); #2 req0_valid = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = EN;
    end
    chk("t6_en_up", EN, 1);
    repeat (2) @(posedge clk);
    #3 rst = 1;
    dcount = done_count;
    #1;
    chk("t6_en_async", EN, 0);
    chk("t6_busy_async", busy, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("t6_no_done", done_count, dcount);
    chk("t6_sticky_clr", timeout_sticky, 0);
`ifdef RRAM_ARB_STATS_EN
    chk("t6_stat_ops", stat_ops, 16'd0);
    chk("t6_stat_to", stat_timeouts, 8'd0);
`endif

    // contention from reset with both commands held
    ack_delay = 0;
    grants.delete();
    min_gap = 1000; had_pulse = 0;
    req0_valid = 1;
    rst = 0;
    for (int i = 0; i < 200 && grants.size() < 4; i++) @(negedge clk);
    @(posedge clk); #2;
    req0_valid = 0; req1_valid = 0;
    if (grants.size() < 4) begin
      n_tests++; n_failed++;
      $display("FAIL t3_grant_count: got %0d, expected 4", grants.size());
    end else begin
      chk("t3_grant0", grants[0], 0);
      chk("t3_grant1", grants[1], 1);
      chk("t3_grant2", grants[2], 0);
      chk("t3_grant3", grants[3], 1);
    end
    repeat (15) @(posedge clk);
    chk("t3_dead_cycle", min_gap >= 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/rram_port_arbiter.md
Name: rram_port_arbiter

Overview:
Shares the single NEUROMORPHIC_X1 functional port (EN/R_WB/DI/AD/SEL/DO/func_ack) between two requesters:
- req0: Wishbone-side host path.
- req1: on-chip inference/DMA engine.

The block does three things: round-robin arbitration, holding one outstanding command on the macro until func_ack, and a watchdog that aborts hung operations. It sits between the requesters and the NEUROMORPHIC_X1 instance, and drives the macro's command pins directly.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles EN may stay high without func_ack before abort; legal range 2..65535.
- TO_W, 16: width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- wb_clk_i  in  1: single clock; all logic is rising-edge.
- wb_rst_i  in  1: reset, asynchronous, active-high.
- req0_valid / req1_valid  in  1: command request; held until reqN_ready.
- req0_rwb / req1_rwb  in  1: 1 = read, 0 = write.
- req0_addr / req1_addr  in  32: macro address.
- req0_wdata / req1_wdata  in  32: write data.
- req0_sel / req1_sel  in  4: byte select.
- req0_ready / req1_ready  out  1: one-cycle accept pulse.
- req0_done / req1_done  out  1: one-cycle completion pulse.
- req0_rdata / req1_rdata  out  32: read data; valid while reqN_done is high.
- req0_err / req1_err  out  1: high with reqN_done when the operation timed out.
- EN  out  1: macro enable.
- R_WB  out  1: macro read/write (1 = read).
- DI  out  32: macro write data.
- AD  out  32: macro address.
- SEL  out  4: macro byte select.
- DO  in  32: macro read data.
- func_ack  in  1: macro completion.
- busy  out  1: high in ISSUE, WAIT or DONE.
- timeout_sticky  out  1: set on any timeout; cleared only by reset.

Behaviour:
- Reset (async, immediate): FSM goes to IDLE. All outputs are 0, including EN (dropped mid-operation with no done pulse). The round-robin pointer is set to favour req0. The watchdog counter is 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any reqN_valid is high, pick a winner.
  - If only one is valid, it wins.
  - If both are valid, the pointer-favoured requester wins, and the pointer then flips to favour the other.
  - Winner: pulse reqN_ready for 1 cycle, latch rwb/addr/wdata/sel and the requester id, go to ISSUE.
- ISSUE (1 cycle): drive EN=1 with the latched R_WB/AD/DI/SEL, clear the watchdog, go to WAIT.
- WAIT:
  - EN stays 1 and the command fields are held stable.
  - The watchdog increments every cycle.
  - func_ack=1: capture DO (reads only; writes capture 0), set err=0, go to DONE.
  - Otherwise, when watchdog == TIMEOUT_CYCLES-1: rdata=0, err=1, set timeout_sticky, go to DONE.
  - If func_ack and watchdog expiry occur in the same cycle, func_ack wins (no error).
- DONE (1 cycle):
  - EN=0.
  - reqN_done=1 for the latched id only; reqN_rdata and reqN_err are valid on this cycle.
  - Next state is IDLE. Back-to-back commands therefore have at least 1 dead cycle between EN pulses.
- Latency: valid-to-ready is 1 cycle in IDLE. EN rises the cycle after ready. done follows the func_ack cycle by 1 cycle.
- Outside WAIT:
  - func_ack is ignored.
  - A request made while busy waits; it is not dropped.
  - Deasserting valid before ready is permitted; the request is then not taken.
- reqN_rdata holds its value after done until the next done for that requester.

Optional Feature:
Macro RRAM_ARB_STATS_EN.
- Defined: adds two outputs.
  - stat_ops, 16-bit: count of completed operations; wraps at 16'hFFFF → 0.
  - stat_timeouts, 8-bit: count of timeouts; saturates at 8'hFF.
  - Both update on the DONE cycle and reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package/include rram_arb_pkg holds:
  - the FSM state encodings;
  - RWB_READ = 1 and RWB_WRITE = 0;
  - requester id constants REQ0 = 0 and REQ1 = 1;
  - the default TIMEOUT_CYCLES.
- One sub-module, rram_arb_rr_pick: a 2-way round-robin picker with the pointer register inside. It takes the two valid bits and an advance strobe, and produces a grant id and grant_valid.

Test Plan:
1. Single write: req0 writes addr 0x10, wdata 0xA5A5_0001, sel 0xF; macro acks 3 cycles after EN. Expect EN high for 4 cycles; req0_done with err=0 one cycle after ack; req1 outputs stay 0.
2. Read: req1 reads addr 0x20; macro returns DO=0xDEAD_BEEF with func_ack. Expect req1_rdata=0xDEADBEEF on the req1_done cycle.
3. Contention: both valid from reset, commands held. Expect grant order req0, req1, req0, req1, with a dead cycle between EN pulses.
4. Timeout: TIMEOUT_CYCLES=8, no ack. Expect EN high for exactly 8 cycles, req0_done with err=1 and rdata=0, and timeout_sticky=1. Then a normal op completes with err=0 and the sticky bit still set.
5. Ack/expiry race: func_ack arrives on the expiry cycle. Expect err=0 and timeout_sticky unchanged.
6. Reset mid-WAIT: assert wb_rst_i asynchronously (between clock edges). Expect EN=0 immediately, no done pulse, and req0 favoured on the first post-reset contention. With RRAM_ARB_STATS_EN, stat_ops/stat_timeouts read 0 after reset and 2/1 after tests 1 and 4.
